// File: rtl/fetch_unit_if.sv
// Instruction fetch handshake bundle: start control, memory read port, decode port.
// Latency: none (wiring only).
// Backpressure: memory side is req/ack, decode side is decode/next; halt stops fetching.
//
// Signals (named from the fetch unit's point of view):
//   i_start, i_start_pc        start fetching at a given address
//   o_mem_req, o_mem_addr      memory read request, held until i_mem_ack
//   i_mem_ack, i_mem_data      read completion and data, same cycle
//   o_insn, o_pc, o_decode     instruction presented to the decoder, held until i_next
//   i_next, i_halt             downstream consumed / downstream halted
//   o_halted                   fetch unit is in its halted state
interface fetch_unit_if;
    logic        i_start;
    logic [31:0] i_start_pc;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic [31:0] o_insn;
    logic        o_decode;
    logic        i_next;
    logic        i_halt;
    logic [31:0] o_pc;
    logic        o_halted;

    modport master (
        input  i_start, i_start_pc, i_mem_ack, i_mem_data, i_next, i_halt,
        output o_mem_req, o_mem_addr, o_insn, o_decode, o_pc, o_halted
    );

    modport slave (
        output i_start, i_start_pc, i_mem_ack, i_mem_data, i_next, i_halt,
        input  o_mem_req, o_mem_addr, o_insn, o_decode, o_pc, o_halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch: reads word-aligned addresses and hands each word to the decoder.
// Latency: ack in cycle n gives o_decode in cycle n+1; start to first o_decode is 2 cycles at 0 wait.
// Backpressure: o_decode held until i_next; memory request held until i_mem_ack (never aborted).
//
// Ports: i_clk, i_rst (async, active high) plus fetch_unit_if.master bus (see fetch_unit_if.sv).
// Optional: define FETCH_PREFETCH_EN to add a one-entry prefetch buffer that fetches o_pc+4
// while the current word sits in decode, allowing one instruction per cycle on 0-wait memory.
module fetch_unit (
    input  logic             i_clk,
    input  logic             i_rst,
    fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] insn;
    logic        decode;
    logic [31:0] pc;
    logic        halted;
    // Halt seen while a read was in flight; the read must still complete before halting.
    logic        halt_pend;

    // An ack only counts while a request is actually outstanding.
    logic        ack;
    assign ack = bus.i_mem_ack & mem_req;

`ifdef FETCH_PREFETCH_EN
    logic        pf_vld;
    logic [31:0] pf_dat;
    logic [31:0] pf_addr;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            insn      <= 32'd0;
            decode    <= 1'b0;
            pc        <= 32'd0;
            halted    <= 1'b0;
            halt_pend <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_vld    <= 1'b0;
            pf_dat    <= 32'd0;
            pf_addr   <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE, HALTED: begin
                    // Start takes priority so a halted unit can be restarted while
                    // downstream still holds its halt line.
                    if (bus.i_start) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= {bus.i_start_pc[31:2], 2'b00};
                        halted    <= 1'b0;
                        halt_pend <= 1'b0;
                    end else if (bus.i_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end

                REQ: begin
                    if (ack) begin
                        if (bus.i_halt || halt_pend) begin
                            // Read finished but nobody wants it: drop the data.
                            mem_req   <= 1'b0;
                            halt_pend <= 1'b0;
                            halted    <= 1'b1;
                            state     <= HALTED;
                        end else begin
                            insn   <= bus.i_mem_data;
                            pc     <= mem_addr;
                            decode <= 1'b1;
                            state  <= HOLD;
`ifdef FETCH_PREFETCH_EN
                            mem_req  <= 1'b1;
                            mem_addr <= mem_addr + 32'd4;
`else
                            mem_req  <= 1'b0;
`endif
                        end
                    end else if (bus.i_halt) begin
                        halt_pend <= 1'b1;
                    end
                end

                HOLD: begin
`ifdef FETCH_PREFETCH_EN
                    if (bus.i_halt) begin
                        decode <= 1'b0;
                        pf_vld <= 1'b0;
                        if (mem_req && !ack) begin
                            // Prefetch still in flight: let it finish, then halt.
                            state     <= REQ;
                            halt_pend <= 1'b1;
                        end else begin
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                            state   <= HALTED;
                        end
                    end else if (bus.i_next) begin
                        if (pf_vld) begin
                            insn     <= pf_dat;
                            pc       <= pf_addr;
                            pf_vld   <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= pf_addr + 32'd4;
                        end else if (ack) begin
                            // Prefetch lands in the same cycle it is needed: bypass the buffer.
                            insn     <= bus.i_mem_data;
                            pc       <= mem_addr;
                            mem_addr <= mem_addr + 32'd4;
                        end else if (mem_req) begin
                            decode <= 1'b0;
                            state  <= REQ;
                        end else begin
                            decode   <= 1'b0;
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc + 32'd4;
                        end
                    end else begin
                        if (ack) begin
                            pf_vld  <= 1'b1;
                            pf_dat  <= bus.i_mem_data;
                            pf_addr <= mem_addr;
                            mem_req <= 1'b0;
                        end else if (!mem_req && !pf_vld) begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc + 32'd4;
                        end
                    end
`else
                    // Halt beats next when both arrive together.
                    if (bus.i_halt) begin
                        decode <= 1'b0;
                        halted <= 1'b1;
                        state  <= HALTED;
                    end else if (bus.i_next) begin
                        decode   <= 1'b0;
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc + 32'd4;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_mem_req  = mem_req;
    assign bus.o_mem_addr = mem_addr;
    assign bus.o_insn     = insn;
    assign bus.o_decode   = decode;
    assign bus.o_pc       = pc;
    assign bus.o_halted   = halted;

endmodule
